// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: dual-lane instruction fetch buffer between IF and ID.
// Tracks the AHB data phase of both fetch ports, restores program order and
// queues instruction pairs for ID. Drives fetch back-pressure and drops
// in-flight / buffered fetches on redirect or clear.
// Optional feature macro: IF_BUF_FAULT_EN (bus-error tagging, id_fault_* ports).

// Per-lane data-phase capture: parks the first-arriving word until the
// partner lane completes.
module if_fetch_buffer_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        clr,
  input  logic        hready,
  input  logic [31:0] hrdata,
`ifdef IF_BUF_FAULT_EN
  input  logic        hresp,
  output logic        flt,
`endif
  output logic        fin,
  output logic [31:0] word
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        done_q;
  logic [31:0] data_q;
  logic [31:0] rd_word;

`ifdef IF_BUF_FAULT_EN
  logic fault_q;
  assign rd_word = hresp ? NOP : hrdata;
  assign flt     = done_q ? fault_q : hresp;
`else
  assign rd_word = hrdata;
`endif

  // Lane is finished once it has completed earlier or completes now.
  assign fin  = active & (done_q | hready);
  assign word = done_q ? data_q : rd_word;

  // Latch the word on first completion; re-arm when the pair retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      data_q  <= NOP;
`ifdef IF_BUF_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else if (clr) begin
      done_q  <= 1'b0;
    end else if (active && !done_q && hready) begin
      done_q  <= 1'b1;
      data_q  <= rd_word;
`ifdef IF_BUF_FAULT_EN
      fault_q <= hresp;
`endif
    end
  end
endmodule

module if_fetch_buffer #(
  parameter int DEPTH = 2   // 2 or 4 pair entries
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_output_ACT,
  input  logic [31:0] s_if_pc1_Q,
  input  logic [31:0] s_if_pc2_Q,
  input  logic        s_if_swap,
  input  logic [31:0] if1_ahb_HRDATA,
  input  logic [31:0] if2_ahb_HRDATA,
  input  logic        if1_ahb_HREADY,
  input  logic        if2_ahb_HREADY,
  input  logic        if1_ahb_HRESP,
  input  logic        if2_ahb_HRESP,
  input  logic        s_if_jump_D,
  input  logic        r_id_clear_Q,
  input  logic        id_take_a,
  input  logic        id_take_b,
  output logic        fetch_hold,
  output logic        id_valid_a,
  output logic        id_valid_b,
  output logic [31:0] id_inst_a,
  output logic [31:0] id_inst_b,
  output logic [31:0] id_pc_a,
  output logic [31:0] id_pc_b
`ifdef IF_BUF_FAULT_EN
  ,
  output logic        id_fault_a,
  output logic        id_fault_b
`endif
);
  localparam int NUM_LANES = 2;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        vld;
    logic        squash;
    logic        swap;
    logic [31:0] pc_old;
    logic [31:0] pc_young;
  } phase_t;

  typedef struct packed {
    logic        valid_a;
    logic        valid_b;
    logic [31:0] inst_a;
    logic [31:0] inst_b;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
`ifdef IF_BUF_FAULT_EN
    logic        fault_a;
    logic        fault_b;
`endif
  } entry_t;

  // Lane 0 is port 1, lane 1 is port 2.
  logic [NUM_LANES-1:0]       hready, fin;
  logic [NUM_LANES-1:0][31:0] hrdata, word;
`ifdef IF_BUF_FAULT_EN
  logic [NUM_LANES-1:0]       hresp, flt;
  assign hresp = {if2_ahb_HRESP, if1_ahb_HRESP};
`else
  logic unused_hresp;
  assign unused_hresp = if1_ahb_HRESP ^ if2_ahb_HRESP;
`endif
  assign hready = {if2_ahb_HREADY, if1_ahb_HREADY};
  assign hrdata = {if2_ahb_HRDATA, if1_ahb_HRDATA};

  // cur is the data phase on the bus; nxt is an address accepted while cur
  // was still stalled, which starts its data phase once cur retires.
  phase_t cur, nxt, cur_d, nxt_d, new_ph;
  logic   flush, fire, pair_done, push, pop, take_b_ok;
  logic [1:0]    n_out;
  logic [OW-1:0] occ;

  entry_t          q [DEPTH];
  entry_t          hd, enq;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    if_fetch_buffer_lane u_lane (
      .clk    (CLK),
      .rst    (RST),
      .active (cur.vld),
      .clr    (pair_done),
      .hready (hready[l]),
      .hrdata (hrdata[l]),
`ifdef IF_BUF_FAULT_EN
      .hresp  (hresp[l]),
      .flt    (flt[l]),
`endif
      .fin    (fin[l]),
      .word   (word[l])
    );
  end

  assign flush     = s_if_jump_D | r_id_clear_Q;
  assign pair_done = cur.vld & (&fin);
  assign push      = pair_done & ~cur.squash & ~flush;

  // Credit: buffered pairs plus phases that will still be outstanding after
  // this cycle; a second stalled address also blocks further issue.
  assign n_out      = 2'(cur.vld & ~pair_done) + 2'(nxt.vld);
  assign occ        = OW'(count) + OW'(n_out);
  assign fetch_hold = (occ >= OW'(DEPTH)) | (nxt.vld & ~pair_done);
  assign fire       = if_output_ACT & ~fetch_hold;

  // Capture the issuing address phase in program order.
  always_comb begin
    new_ph          = '0;
    new_ph.vld      = 1'b1;
    new_ph.swap     = s_if_swap;
    new_ph.pc_old   = s_if_swap ? s_if_pc2_Q : s_if_pc1_Q;
    new_ph.pc_young = s_if_swap ? s_if_pc1_Q : s_if_pc2_Q;
  end

  // Phase tracker next state: squash on flush, retire on completion, then
  // place a new issue (never squashed, even in the flush cycle).
  always_comb begin
    cur_d = cur;
    nxt_d = nxt;
    if (flush) begin
      cur_d.squash = cur.squash | cur.vld;
      nxt_d.squash = nxt.squash | nxt.vld;
    end
    if (pair_done) begin
      cur_d = nxt_d;
      nxt_d = '0;
    end
    if (fire) begin
      if (cur_d.vld) nxt_d = new_ph;
      else           cur_d = new_ph;
    end
  end

  // Phase tracker state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur <= '0;
      nxt <= '0;
    end else begin
      cur <= cur_d;
      nxt <= nxt_d;
    end
  end

  // Build the ordered pair: slot A always carries the older PC.
  always_comb begin
    enq         = '0;
    enq.valid_a = 1'b1;
    enq.valid_b = 1'b1;
    enq.pc_a    = cur.pc_old;
    enq.pc_b    = cur.pc_young;
    enq.inst_a  = cur.swap ? word[1] : word[0];
    enq.inst_b  = cur.swap ? word[0] : word[1];
`ifdef IF_BUF_FAULT_EN
    enq.fault_a = cur.swap ? flt[1] : flt[0];
    enq.fault_b = cur.swap ? flt[0] : flt[1];
`endif
  end

  assign hd = q[head_q];
  // Slot B may only retire with or after slot A; anything else is dropped.
  assign take_b_ok = id_take_b & (~hd.valid_a | id_take_a);
  assign pop = (count != '0) & ~(hd.valid_a & ~id_take_a) & ~(hd.valid_b & ~take_b_ok);

  // Pair FIFO: flush beats everything; a push to the tail overrides the
  // head valid update when a full buffer pops and pushes together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i]        <= '0;
        q[i].inst_a <= NOP;
        q[i].inst_b <= NOP;
      end
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid_a <= 1'b0;
        q[i].valid_b <= 1'b0;
      end
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else begin
      if (count != '0) begin
        q[head_q].valid_a <= hd.valid_a & ~id_take_a;
        q[head_q].valid_b <= hd.valid_b & ~take_b_ok;
      end
      if (push) begin
        q[tail_q] <= enq;
        tail_q    <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign id_valid_a = hd.valid_a;
  assign id_valid_b = hd.valid_b;
  assign id_inst_a  = hd.inst_a;
  assign id_inst_b  = hd.inst_b;
  assign id_pc_a    = hd.pc_a;
  assign id_pc_b    = hd.pc_b;
`ifdef IF_BUF_FAULT_EN
  assign id_fault_a = hd.fault_a;
  assign id_fault_b = hd.fault_b;
`endif

`ifndef SYNTHESIS
  // ID must never retire slot B ahead of an unretired slot A.
  assert property (@(posedge CLK) disable iff (RST)
    !(id_take_b && id_valid_a && !id_take_a));
  // A pair must never land in a full buffer without a same-cycle pop.
  assert property (@(posedge CLK) disable iff (RST)
    !(push && count == CW'(DEPTH) && !pop));
`endif
endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

Dual-lane instruction fetch buffer between the IF stage and the ID stage of the superscalar core. Tracks the AHB data phase of the two instruction-fetch ports, captures both instruction words with their PCs, restores program order, and queues them as pairs for ID. It generates fetch back-pressure and discards in-flight and buffered fetches on redirect or clear.

## Interface
- DEPTH, 2: number of instruction-pair entries; must be 2 or 4.
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- if_output_ACT  in  1  IF issued an address phase this cycle on both ports.
- s_if_pc1_Q, s_if_pc2_Q  in  32 each  address-phase PCs of port 1 and port 2.
- s_if_swap  in  1  port 1 carries the younger instruction; equals fetch_order & ~clear.
- if1_ahb_HRDATA, if2_ahb_HRDATA  in  32 each  read data.
- if1_ahb_HREADY, if2_ahb_HREADY  in  1 each  data-phase completion.
- if1_ahb_HRESP, if2_ahb_HRESP  in  1 each  error response.
- s_if_jump_D  in  1  redirect from ID, EX or ME; flush.
- r_id_clear_Q  in  1  ID clear; flush.
- id_take_a, id_take_b  in  1 each  ID consumes slot A or slot B of the head entry.
- fetch_hold  out  1  IF must not issue a new address phase.
- id_valid_a, id_valid_b  out  1 each  head slot is valid.
- id_inst_a, id_inst_b  out  32 each  head instructions; A is older.
- id_pc_a, id_pc_b  out  32 each  PCs of the head instructions.
- id_fault_a, id_fault_b  out  1 each  bus error on that slot. Present only with IF_BUF_FAULT_EN.

## Operation
- **Data-phase tracker.** Registers inflight, squash, pc_old, pc_young, swap and per-lane done/data.
  - Set on if_output_ACT while fetch_hold=0.
- **Lane completion.** Each lane completes independently when its HREADY=1.
  - A completed lane latches its data and holds it until the other lane completes.
  - Pair completion is the cycle in which the second lane completes; both lanes may complete in the same cycle.
- **Ordering.** With swap=0, port 1 fills slot A and port 2 fills slot B. With swap=1, the lanes are crossed. Slot A always carries the lower-order (older) PC.
- **Enqueue.** At pair completion, if squash=0, write {inst, pc, fault} for both slots with valid_a = valid_b = 1 to the tail entry. If squash=1, drop the pair.
- **Dequeue.**
  - id_take_a clears valid_a of the head entry; id_take_b clears valid_b.
  - id_take_b while valid_a=1 and id_take_a=0 is illegal. Assert it in simulation; the RTL ignores it.
  - The head entry pops in the cycle both valids become (or already are) 0. A new pair may enqueue in the same cycle.
- **Credit.** fetch_hold = (count + inflight_pending >= DEPTH). inflight_pending counts the current data phase when it will not complete this cycle.
- **Flush.** When s_if_jump_D or r_id_clear_Q is 1:
  - All entries are invalidated and count becomes 0 in the next cycle.
  - An in-flight pair is marked squash=1 and dropped on completion.
  - A fetch issued in the flush cycle is the redirected fetch; it is not squashed.
  - fetch_hold=0 in the cycle after a flush unless a squashed phase is still pending.
- **Simultaneous events.** Flush has priority over enqueue and dequeue. Dequeue with enqueue into a full buffer is allowed.
- **Pointers.** Head and tail pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.

## Timing
- Reset values:
  - Outputs: fetch_hold=0, all id_valid_*=0, id_inst_*=0x00000013 (NOP), id_pc_*=0, id_fault_*=0.
  - State: count=0, inflight=0, squash=0.
- Fetch-to-ID latency: address phase in cycle n, HREADY in n+1, id_valid in n+2. ID outputs are registered from the FIFO head.
- Wait states: each cycle of HREADY=0 on either lane adds one cycle.
- fetch_hold is combinational from registered state and the current HREADY inputs.
- Reset mid-transfer clears all state asynchronously. Any later HREADY for the lost phase is ignored because inflight=0.

## Configuration
- IF_BUF_FAULT_EN defined:
  - HRESP=1 at completion stores fault=1 and the instruction 0x00000013; id_fault_* outputs exist.
  - A fault does not stop fetching.
- Undefined: HRESP is ignored, HRDATA is stored as-is, and the id_fault_* ports are absent.

## Test plan
- **Basic pair.** Reset, then ACT with pc1=0x100, pc2=0x104, swap=0; both HREADY=1 next cycle with data 0xAAAA0001/0xBBBB0002. Two cycles later: valid_a=valid_b=1, pc_a=0x100, inst_b=0xBBBB0002.
- **Swap with skewed wait.** swap=1, pc1=0x204, pc2=0x200; port 2 is ready one cycle before port 1. Expect one enqueue only, with slot A pc=0x200 carrying port 2's data.
- **Fill and back-pressure.** DEPTH=2, id_take_*=0, issue three pairs. fetch_hold=1 once count+inflight=2. A single id_take_a/b pop in the same cycle as an enqueue keeps count=2.
- **Partial consume.** Pulse id_take_a only: valid_a=0, valid_b=1, head unchanged. Then pulse id_take_b: the entry pops.
- **Flush with in-flight.** Raise s_if_jump_D during a data phase with HREADY=0 for 3 cycles. The squashed pair is never visible; a new fetch at 0x400 issued in the flush cycle appears at ID.
- **Fault.** With IF_BUF_FAULT_EN, HRESP=1 on port 2 gives id_fault_b=1 and inst_b=0x00000013. Reset asserted mid-phase clears valid and hold immediately.
